// File: rtl/plot_sink_pkg.sv
// Shared types and geometry for the plot sink framebuffer.
// Default geometry is 160x120; addresses are row-major y*WIDTH + x.
package plot_sink_pkg;

  localparam int unsigned DEF_WIDTH  = 160;
  localparam int unsigned DEF_HEIGHT = 120;
  localparam int unsigned FB_DEPTH   = 19200;
  localparam int unsigned ADDR_W     = 15;

  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    DUMP  = 2'd2
  } state_t;

  function automatic fb_addr_t fb_addr(input logic [7:0] x, input logic [6:0] y,
                                       input int unsigned w);
    fb_addr_t w_cols;
    w_cols = fb_addr_t'(w);
    return fb_addr_t'(y) * w_cols + fb_addr_t'(x);
  endfunction

endpackage

// File: rtl/plot_sink_if.sv
// Plot and readout signals of the plot sink; master drives plots and rd_ready.
// The slave side (the sink) drives the readout beat, status and counters.
interface plot_sink_if;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        dump_start;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [2:0]  rd_colour;
  logic        rd_valid;
  logic        rd_ready;
  logic        dump_done;
  logic        busy;
  logic [15:0] plot_count;
  logic [7:0]  oob_count;
  logic [15:0] checksum;

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, dump_start, rd_ready,
    input  rd_x, rd_y, rd_colour, rd_valid, dump_done, busy,
           plot_count, oob_count, checksum
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, dump_start, rd_ready,
    output rd_x, rd_y, rd_colour, rd_valid, dump_done, busy,
           plot_count, oob_count, checksum
  );
endinterface

// File: rtl/plot_sink_fb_ram.sv
// Simple dual-port 3-bit framebuffer memory, one write and one registered read port.
// Read latency 1 cycle; a read colliding with a write to the same address returns the old colour.
module fb_ram
  import plot_sink_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH
) (
  input  logic       CLOCK_50,
  input  logic       i_we,
  input  fb_addr_t   i_waddr,
  input  logic [2:0] i_wdat,
  input  logic       i_re,
  input  fb_addr_t   i_raddr,
  output logic [2:0] o_rdat
);

  logic [2:0] r_mem [DEPTH];
  logic [2:0] r_rdat;

  always_ff @(posedge CLOCK_50) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
    if (i_re) begin
      r_rdat <= r_mem[i_raddr];
    end
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/plot_sink.sv
// Plot sink: clears the framebuffer after reset, accepts plots, dumps it row-major over valid/ready.
// First beat 2 cycles after dump_start, then at most one beat per 2 cycles; macro PLOT_SINK_CHECKSUM_EN adds a beat checksum.
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT
) (
  input logic        CLOCK_50,
  input logic        rst_n,
  plot_sink_if.slave bus
);

  localparam int unsigned DEPTH     = WIDTH * HEIGHT;
  localparam fb_addr_t    LAST_ADDR = fb_addr_t'(DEPTH - 1);
  localparam logic [7:0]  LAST_X    = 8'(WIDTH - 1);
  localparam logic [6:0]  LAST_Y    = 7'(HEIGHT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  fb_addr_t   r_clr_addr;
  logic [7:0] r_cur_x;
  logic [6:0] r_cur_y;
  fb_addr_t   r_cur_addr;
  logic       r_rd_pend;
  logic       r_rd_valid;
  logic [7:0] r_rd_x;
  logic [6:0] r_rd_y;
  logic [2:0] r_rd_colour;
  logic       r_dump_done;
  logic [15:0] r_plot_count;
  logic [7:0]  r_oob_count;

  logic       w_in_range;
  logic       w_plot_live;
  logic       w_plot_ok;
  logic       w_plot_oob;
  logic       w_accept;
  logic       w_last_beat;
  logic       w_dump_go;
  logic [7:0] w_nxt_x;
  logic [6:0] w_nxt_y;
  logic       w_re;
  fb_addr_t   w_raddr;
  logic [2:0] w_ram_rdat;
  logic       w_we;
  fb_addr_t   w_waddr;
  logic [2:0] w_wdat;
  logic       w_busy;

  assign w_in_range  = ({1'b0, bus.vga_x} < 9'(WIDTH)) && ({1'b0, bus.vga_y} < 8'(HEIGHT));
  assign w_plot_live = bus.vga_plot && (r_state != CLEAR);
  assign w_plot_ok   = w_plot_live && w_in_range;
  assign w_plot_oob  = w_plot_live && !w_in_range;

  // r_cur_* always names the beat being fetched or presented.
  assign w_accept    = r_rd_valid && bus.rd_ready;
  assign w_last_beat = w_accept && (r_cur_x == LAST_X) && (r_cur_y == LAST_Y);
  assign w_dump_go   = (r_state == IDLE) && bus.dump_start;
  assign w_nxt_x     = (r_cur_x == LAST_X) ? 8'd0 : r_cur_x + 8'd1;
  assign w_nxt_y     = (r_cur_x == LAST_X) ? r_cur_y + 7'd1 : r_cur_y;

  // The next read is launched on the acceptance edge, so its data lands one cycle later.
  assign w_re    = w_dump_go || (w_accept && !w_last_beat);
  assign w_raddr = w_dump_go ? '0 : r_cur_addr + fb_addr_t'(1);

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_clr_addr == LAST_ADDR) w_state_nxt = IDLE;
      IDLE:    if (bus.dump_start) w_state_nxt = DUMP;
      DUMP:    if (w_last_beat) w_state_nxt = IDLE;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    w_busy  = 1'b1;
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdat  = 3'b000;
    case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
      end
      IDLE, DUMP: begin
        w_busy  = (r_state == DUMP);
        w_we    = w_plot_ok;
        w_waddr = fb_addr(bus.vga_x, bus.vga_y, WIDTH);
        w_wdat  = bus.vga_colour;
      end
      default: begin
        w_busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_clr_addr   <= '0;
      r_cur_x      <= 8'd0;
      r_cur_y      <= 7'd0;
      r_cur_addr   <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_x       <= 8'd0;
      r_rd_y       <= 7'd0;
      r_rd_colour  <= 3'b000;
      r_dump_done  <= 1'b0;
      r_plot_count <= 16'd0;
      r_oob_count  <= 8'd0;
    end else begin
      r_clr_addr  <= (r_state == CLEAR) ? r_clr_addr + fb_addr_t'(1) : '0;
      r_rd_pend   <= w_re;
      r_dump_done <= w_last_beat;

      if (w_dump_go) begin
        r_cur_x    <= 8'd0;
        r_cur_y    <= 7'd0;
        r_cur_addr <= '0;
      end else if (w_accept && !w_last_beat) begin
        r_cur_x    <= w_nxt_x;
        r_cur_y    <= w_nxt_y;
        r_cur_addr <= w_raddr;
      end

      if (r_rd_pend) begin
        r_rd_valid  <= 1'b1;
        r_rd_x      <= r_cur_x;
        r_rd_y      <= r_cur_y;
        r_rd_colour <= w_ram_rdat;
      end else if (w_accept) begin
        r_rd_valid  <= 1'b0;
      end

      if (w_plot_ok && (r_plot_count != 16'hFFFF)) begin
        r_plot_count <= r_plot_count + 16'd1;
      end
      if (w_plot_oob && (r_oob_count != 8'hFF)) begin
        r_oob_count <= r_oob_count + 8'd1;
      end
    end
  end

  fb_ram #(
    .DEPTH (DEPTH)
  ) u_fb_ram (
    .CLOCK_50 (CLOCK_50),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdat   (w_wdat),
    .i_re     (w_re),
    .i_raddr  (w_raddr),
    .o_rdat   (w_ram_rdat)
  );

`ifdef PLOT_SINK_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      r_checksum <= 16'h0000;
    end else if (w_dump_go) begin
      r_checksum <= 16'h0000;
    end else if (w_accept) begin
      r_checksum <= r_checksum + {13'b0, r_rd_colour};
    end
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = 16'h0000;
`endif

  assign bus.rd_x       = r_rd_x;
  assign bus.rd_y       = r_rd_y;
  assign bus.rd_colour  = r_rd_colour;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.dump_done  = r_dump_done;
  assign bus.busy       = w_busy;
  assign bus.plot_count = r_plot_count;
  assign bus.oob_count  = r_oob_count;

endmodule

// File: tb/tb_plot_sink.sv
// Bench for plot_sink: random plots against an array model, dumps checked by a beat scoreboard.
module tb_plot_sink;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  plot_sink_if bus();

  plot_sink #(.WIDTH(160), .HEIGHT(120)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q [$];
  logic [2:0]  model_fb [19200];
  int          model_plots = 0;
  int          model_oob   = 0;
  int          exp_sum     = 0;

  bit          mon_en      = 1'b0;
  bit          expect_done = 1'b0;
  bit          done_seen   = 1'b0;
  int          done_cnt    = 0;
  int          acc_cnt     = 0;
  int          acc_age     = 0;
  bit          prev_hold   = 1'b0;
  logic [17:0] hold_beat;
  bit          stall_done  = 1'b0;
  int          stall_left  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted beat is popped and compared.
  initial begin
    logic [17:0] act;
    logic [17:0] e;
    forever begin
      @(negedge CLOCK_50);
      act = {bus.rd_x, bus.rd_y, bus.rd_colour};
      if (!mon_en) begin
        prev_hold   = 1'b0;
        acc_age     = 0;
        expect_done = 1'b0;
      end else begin
        if (bus.dump_done) done_cnt++;
        if (prev_hold) begin
          check("hold_valid", 32'(bus.rd_valid), 32'd1);
          check("hold_beat", 32'(act), 32'(hold_beat));
        end
        if (acc_age == 1) begin
          check("gap_after_accept", 32'(bus.rd_valid), 32'd0);
          acc_age = 2;
        end else if (acc_age == 2) begin
          check("next_beat_ready", 32'(bus.rd_valid), 32'd1);
          acc_age = 0;
        end
        if (expect_done || bus.dump_done) begin
          check("dump_done", 32'(bus.dump_done), 32'(expect_done));
          if (expect_done) begin
            check("valid_after_last", 32'(bus.rd_valid), 32'd0);
            check("busy_after_last", 32'(bus.busy), 32'd0);
            done_seen = 1'b1;
          end
          expect_done = 1'b0;
        end
        if (bus.rd_valid && bus.rd_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(act), 32'h3FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'(act), 32'(e));
            acc_cnt++;
            if (exp_q.size() == 0) expect_done = 1'b1;
            else acc_age = 1;
          end
        end
        prev_hold = bus.rd_valid && !bus.rd_ready;
        hold_beat = act;
      end
    end
  end

  // rd_ready: mostly high, one forced 5-cycle stall on beat (3,0), occasional random stalls.
  initial begin
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (stall_left > 0) begin
        bus.rd_ready = 1'b0;
        stall_left--;
      end else if (bus.rd_valid && bus.rd_x == 8'd3 && bus.rd_y == 7'd0 && !stall_done) begin
        stall_done   = 1'b1;
        bus.rd_ready = 1'b0;
        stall_left   = 4;
      end else begin
        bus.rd_ready = ($urandom_range(7) != 0);
      end
    end
  end

  task automatic plot(input int x, input int y, input int c);
    bus.vga_x      = 8'(x);
    bus.vga_y      = 7'(y);
    bus.vga_colour = 3'(c);
    bus.vga_plot   = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.vga_plot   = 1'b0;
    if (x < 160 && y < 120) begin
      model_fb[y * 160 + x] = 3'(c);
      if (model_plots < 65535) model_plots++;
    end else if (model_oob < 255) begin
      model_oob++;
    end
  endtask

  task automatic start_dump();
    exp_sum = 0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        exp_q.push_back({8'(x), 7'(y), model_fb[y * 160 + x]});
        exp_sum += int'(model_fb[y * 160 + x]);
      end
    end
    acc_cnt   = 0;
    done_cnt  = 0;
    done_seen = 1'b0;
    mon_en    = 1'b1;
    bus.dump_start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.dump_start = 1'b0;
    @(negedge CLOCK_50);
    check("first_beat_lat1", 32'(bus.rd_valid), 32'd0);
    check("busy_in_dump", 32'(bus.busy), 32'd1);
    @(negedge CLOCK_50);
    check("first_beat_lat2", 32'(bus.rd_valid), 32'd1);
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int  clr_cycles;
    bit  mid_plot;
    bit  mid_start;
    bit  bad;
    int  exp_ck;

    bus.vga_x      = 8'd0;
    bus.vga_y      = 7'd0;
    bus.vga_colour = 3'd0;
    bus.vga_plot   = 1'b0;
    bus.dump_start = 1'b0;
    for (int i = 0; i < 19200; i++) model_fb[i] = 3'd0;

    // Reset state.
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_dump_done", 32'(bus.dump_done), 32'd0);
    check("rst_plot_count", 32'(bus.plot_count), 32'd0);
    check("rst_oob_count", 32'(bus.oob_count), 32'd0);
    check("rst_checksum", 32'(bus.checksum), 32'd0);
    check("rst_rd_xyc", 32'({bus.rd_x, bus.rd_y, bus.rd_colour}), 32'd0);
    @(posedge CLOCK_50);
    #1;
    rst_n = 1'b1;

    // CLEAR length; plots and dump_start issued during CLEAR must be dropped.
    clr_cycles = 0;
    for (int n = 1; n <= 20000; n++) begin
      @(posedge CLOCK_50);
      #1;
      clr_cycles = n;
      if (n == 100) begin
        bus.vga_x = 8'd0; bus.vga_y = 7'd0; bus.vga_colour = 3'd7; bus.vga_plot = 1'b1;
      end else if (n == 101) begin
        bus.vga_x = 8'd200;
      end else if (n == 102) begin
        bus.vga_plot = 1'b0;
      end else if (n == 150) begin
        bus.dump_start = 1'b1;
      end else if (n == 151) begin
        bus.dump_start = 1'b0;
      end
      @(negedge CLOCK_50);
      if (!bus.busy) break;
    end
    check("clear_cycles", 32'(clr_cycles), 32'd19200);
    check("clear_plot_count", 32'(bus.plot_count), 32'd0);
    check("clear_oob_count", 32'(bus.oob_count), 32'd0);
    check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
    @(posedge CLOCK_50);
    #1;

    // Random in-range plots, half of them in a small window to force overwrites.
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) plot($urandom_range(15), $urandom_range(3), $urandom_range(7));
      else            plot($urandom_range(159), $urandom_range(119), $urandom_range(7));
    end
    plot(10, 20, 5);
    plot(159, 119, 2);
    @(negedge CLOCK_50);
    check("plot_count_inrange", 32'(bus.plot_count), 32'(model_plots));
    check("oob_zero", 32'(bus.oob_count), 32'd0);
    @(posedge CLOCK_50);
    #1;
    plot(160, 0, 6);
    plot(0, 120, 1);
    @(negedge CLOCK_50);
    check("oob_two", 32'(bus.oob_count), 32'd2);
    check("plot_count_after_oob", 32'(bus.plot_count), 32'(model_plots));
    @(posedge CLOCK_50);
    #1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(1) == 0) plot(160 + $urandom_range(95), $urandom_range(127), $urandom_range(7));
      else                        plot($urandom_range(255), 120 + $urandom_range(7), $urandom_range(7));
    end
    @(negedge CLOCK_50);
    check("oob_saturate", 32'(bus.oob_count), 32'(model_oob));
    check("oob_is_255", 32'(model_oob), 32'd255);
    @(posedge CLOCK_50);
    #1;

    // Full dump with backpressure, a plot mid-dump and an ignored dump_start.
    start_dump();
    mid_plot  = 1'b0;
    mid_start = 1'b0;
    for (int n = 0; n < 60000 && !done_seen; n++) begin
      if (acc_cnt >= 1000 && !mid_plot) begin
        plot(0, 0, 6);
        mid_plot = 1'b1;
      end else if (acc_cnt >= 2000 && !mid_start) begin
        bus.dump_start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        bus.dump_start = 1'b0;
        mid_start = 1'b1;
      end else begin
        @(posedge CLOCK_50);
        #1;
      end
    end
    check("dump_finished", 32'(done_seen), 32'd1);
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
`ifdef PLOT_SINK_CHECKSUM_EN
    exp_ck = exp_sum & 16'hFFFF;
`else
    exp_ck = 0;
`endif
    check("beats_accepted", 32'(acc_cnt), 32'd19200);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("dump_done_pulses", 32'(done_cnt), 32'd1);
    check("checksum", 32'(bus.checksum), 32'(exp_ck));
    check("plot_count_final", 32'(bus.plot_count), 32'(model_plots));
    check("idle_after_dump", 32'(bus.busy), 32'd0);
    @(posedge CLOCK_50);
    #1;

    // Reset in the middle of a dump.
    start_dump();
    for (int n = 0; n < 5000 && acc_cnt < 500; n++) begin
      @(posedge CLOCK_50);
      #1;
    end
    check("reached_beat_500", 32'(acc_cnt >= 500), 32'd1);
    mon_en = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("midrst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd1);
    check("midrst_dump_done", 32'(bus.dump_done), 32'd0);
    check("midrst_plot_count", 32'(bus.plot_count), 32'd0);
    check("midrst_oob_count", 32'(bus.oob_count), 32'd0);
    check("midrst_checksum", 32'(bus.checksum), 32'd0);
    check("midrst_rd_xyc", 32'({bus.rd_x, bus.rd_y, bus.rd_colour}), 32'd0);
    @(posedge CLOCK_50);
    #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge CLOCK_50);
      if (bus.dump_done || bus.rd_valid || !bus.busy) bad = 1'b1;
    end
    check("midrst_quiet_clear", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
